// File: rtl/cordic_vectoring_if.sv
// Valid/ready bundle for the CORDIC vectoring engine:
// operand side (x, y) and result side (magnitude, angle).
interface cordic_vectoring_if #(
  parameter int BIT_WIDTH   = 16,
  parameter int ANGLE_WIDTH = 16
);
  logic                          in_valid;
  logic                          in_ready;
  logic signed [BIT_WIDTH-1:0]   x_in;
  logic signed [BIT_WIDTH-1:0]   y_in;
  logic                          out_valid;
  logic                          out_ready;
  logic [BIT_WIDTH+1:0]          mag_out;
  logic signed [ANGLE_WIDTH-1:0] angle_out;

  modport master (
    output in_valid, x_in, y_in, out_ready,
    input  in_ready, out_valid, mag_out, angle_out
  );

  modport slave (
    input  in_valid, x_in, y_in, out_ready,
    output in_ready, out_valid, mag_out, angle_out
  );
endinterface

// File: rtl/cordic_vectoring.sv
// Iterative CORDIC in vectoring mode: (x, y) -> (K*|v|, atan2(y, x)),
// one micro-rotation per clock, gain left uncompensated.
module cordic_vectoring #(
  parameter int BIT_WIDTH   = 16,
  parameter int ITERATIONS  = 12,
  parameter int ANGLE_WIDTH = 16
) (
  input logic clk,
  input logic rst,
  cordic_vectoring_if.slave bus
);
  localparam int W  = BIT_WIDTH + 2;
  localparam int AW = ANGLE_WIDTH;
  localparam int IW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
  localparam logic [IW-1:0] LAST = IW'(ITERATIONS - 1);
  localparam logic [AW-1:0] QUARTER = AW'(1) << (AW - 2);
  localparam real PI = 3.14159265358979323846;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t               r_state;
  logic signed [W-1:0]  r_x;
  logic signed [W-1:0]  r_y;
  logic [AW-1:0]        r_z;
  logic [IW-1:0]        r_iter;
  logic                 r_out_valid;
  logic [W-1:0]         r_mag;
  logic [AW-1:0]        r_ang;

  logic [AW-1:0] w_atan [ITERATIONS];

  for (genvar g = 0; g < ITERATIONS; g++) begin : g_atan
    localparam real ANG =
      $atan(1.0 / (2.0 ** g)) * (2.0 ** (AW - 1)) / PI;
    assign w_atan[g] = AW'($rtoi(ANG + 0.5));
  end

  logic signed [W-1:0] w_xe;
  logic signed [W-1:0] w_ye;
  logic signed [W-1:0] w_x0;
  logic signed [W-1:0] w_y0;
  logic [AW-1:0]       w_z0;

  assign w_xe = {{2{bus.x_in[BIT_WIDTH-1]}}, bus.x_in};
  assign w_ye = {{2{bus.y_in[BIT_WIDTH-1]}}, bus.y_in};

  // Fold the left half-plane into the right one by +-90 degrees
  always_comb begin
    w_x0 = w_xe;
    w_y0 = w_ye;
    w_z0 = '0;
    unique case (1'b1)
      !w_xe[W-1]: begin
        w_x0 = w_xe;
        w_y0 = w_ye;
        w_z0 = '0;
      end
      w_xe[W-1] && !w_ye[W-1]: begin
        w_x0 = w_ye;
        w_y0 = -w_xe;
        w_z0 = QUARTER;
      end
      default: begin
        w_x0 = -w_ye;
        w_y0 = w_xe;
        w_z0 = -QUARTER;
      end
    endcase
  end

  logic signed [W-1:0] w_xs;
  logic signed [W-1:0] w_ys;
  logic signed [W-1:0] w_x_nx;
  logic signed [W-1:0] w_y_nx;
  logic [AW-1:0]       w_z_nx;
  logic                w_neg;

  assign w_xs   = r_x >>> r_iter;
  assign w_ys   = r_y >>> r_iter;
  assign w_neg  = r_y[W-1];
  assign w_x_nx = w_neg ? r_x - w_ys : r_x + w_ys;
  assign w_y_nx = w_neg ? r_y + w_xs : r_y - w_xs;
  assign w_z_nx = w_neg ? r_z - w_atan[r_iter]
                        : r_z + w_atan[r_iter];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_z         <= '0;
      r_iter      <= '0;
      r_out_valid <= 1'b0;
      r_mag       <= '0;
      r_ang       <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_x     <= w_x0;
            r_y     <= w_y0;
            r_z     <= w_z0;
            r_iter  <= '0;
            r_state <= ITER;
          end
        end
        ITER: begin
          r_x    <= w_x_nx;
          r_y    <= w_y_nx;
          r_z    <= w_z_nx;
          r_iter <= r_iter + 1'b1;
          if (r_iter == LAST) begin
            r_mag       <= w_x_nx;
            r_ang       <= w_z_nx;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.mag_out   = r_mag;
  assign bus.angle_out = r_ang;
endmodule
